result_sel_reg: RTL and testbench

- Registered, handshaked result selector for the calculator datapath.
- Generalises the fixed 12-bit three-source result mux to N_SRC sources of WIDTH bits.
- The operation select is captured per transaction; the block then waits for the chosen unit's valid, latches its result and holds it until the display/output stage accepts it.
- Sits between the arithmetic units (add/sub, mul, div, ...) and the output register stage.

---
 rtl/result_sel_reg_if.sv | 32 +++
 rtl/result_sel_reg.sv | 145 ++++++++++++++
 tb/tb_result_sel_reg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/result_sel_reg_if.sv
// Handshake bundle between the arithmetic sources, the result selector and the output stage.
// Latency: none, wires only.
// Backpressure: src_ready and dout_ready carry the per-side accept handshakes.
interface result_sel_reg_if #(
  parameter int WIDTH = 12,
  parameter int N_SRC = 3,
  parameter int SEL_W = 2
);
  logic                   start;
  logic [SEL_W-1:0]       sel;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC-1:0]       src_ready;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   busy;
  logic                   sel_err;
  logic [7:0]             done_cnt;

  // Selector side.
  modport slave (
    input  start, sel, src_data, src_valid, dout_ready,
    output src_ready, dout, dout_valid, busy, sel_err, done_cnt
  );

  // Environment side: drives requests and sources, consumes the result.
  modport master (
    output start, sel, src_data, src_valid, dout_ready,
    input  src_ready, dout, dout_valid, busy, sel_err, done_cnt
  );
endinterface

// File: rtl/result_sel_reg.sv
// Registered N-source result selector: captures sel on start, waits for that source, holds result.
// Latency: dout_valid rises 1 cycle after the selected source handshake.
// Backpressure: result held until dout_ready; optional WAIT timeout with macro RSEL_TIMEOUT_EN.
module result_sel_reg #(
  parameter int WIDTH      = 12,
  parameter int N_SRC      = 3,
  parameter int SEL_W      = 2,
  parameter int TMO_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  result_sel_reg_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel_q;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_valid;
  logic               r_sel_err;
  logic               w_sel_err_nxt;
  logic [7:0]         r_done_cnt;
  logic               w_load;
  logic               w_clr_valid;
  logic               w_sel_legal;
  logic               w_xfer;
  logic               w_tmo;
  logic [N_SRC-1:0]   w_src_ready;
  logic [WIDTH-1:0]   w_sel_data;

  assign w_sel_legal = (32'(bus.sel) < N_SRC);
  assign w_xfer      = |(w_src_ready & bus.src_valid);

  // Decode the one-hot source accept and mux out the selected source's data.
  always_comb begin
    w_src_ready = '0;
    w_sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_sel_q == SEL_W'(i)) begin
        w_src_ready[i] = (r_state == S_WAIT);
        w_sel_data     = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef RSEL_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  // The counter is zero on the first WAIT cycle, so the limit is hit on the TMO_CYCLES-th cycle.
  assign w_tmo = (r_state == S_WAIT) && (r_tmo_cnt == 8'(TMO_CYCLES - 1));

  // Count cycles spent in WAIT, restarting on every entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= 8'd0;
    end else if (w_state_nxt == S_WAIT && r_state != S_WAIT) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Next-state logic; a new start is only honoured in IDLE or when HOLD's result is accepted.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel_q;
    w_sel_err_nxt = 1'b0;
    w_load        = 1'b0;
    w_clr_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_sel_legal) begin
            w_sel_nxt   = bus.sel;
            w_state_nxt = S_WAIT;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A transfer on the limit cycle takes priority over the abort.
        if (w_xfer) begin
          w_load      = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (w_tmo) begin
          w_sel_err_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (bus.dout_ready) begin
          w_clr_valid = 1'b1;
          w_state_nxt = S_IDLE;
          if (bus.start) begin
            if (w_sel_legal) begin
              w_sel_nxt   = bus.sel;
              w_state_nxt = S_WAIT;
            end else begin
              w_sel_err_nxt = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, captured select, result register and completion counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_sel_q      <= '0;
      r_sel_err    <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done_cnt   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel_q   <= w_sel_nxt;
      r_sel_err <= w_sel_err_nxt;
      if (w_load) begin
        r_dout       <= w_sel_data;
        r_dout_valid <= 1'b1;
        r_done_cnt   <= r_done_cnt + 8'd1;
      end else if (w_clr_valid) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign bus.src_ready  = w_src_ready;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.sel_err    = r_sel_err;
  assign bus.done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_result_sel_reg.sv
// Directed bench for result_sel_reg (WIDTH=12, N_SRC=3, TMO_CYCLES=4).
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Covers the timeout path when RSEL_TIMEOUT_EN is defined, WAIT persistence otherwise.
module tb_result_sel_reg;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  result_sel_reg_if #(.WIDTH(12), .N_SRC(3), .SEL_W(2)) bus ();

  result_sel_reg #(.WIDTH(12), .N_SRC(3), .SEL_W(2), .TMO_CYCLES(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sel = 2'd0;
    bus.src_data = '0;
    bus.src_valid = 3'b000;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_dout",      32'(bus.dout), 32'h0);
    chk("rst_valid",     32'(bus.dout_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy), 32'h0);
    chk("rst_sel_err",   32'(bus.sel_err), 32'h0);
    chk("rst_done_cnt",  32'(bus.done_cnt), 32'h0);
    chk("rst_src_ready", 32'(bus.src_ready), 32'h0);

    // sel=1 with mul result already valid
    bus.start = 1'b1;
    bus.sel = 2'd1;
    bus.src_data = {12'h333, 12'h0A5, 12'h111};
    bus.src_valid = 3'b010;
    tick();
    bus.start = 1'b0;
    chk("wait_src_ready", 32'(bus.src_ready), 32'h2);
    chk("wait_busy",      32'(bus.busy), 32'h1);
    chk("wait_valid",     32'(bus.dout_valid), 32'h0);
    tick();
    chk("t1_dout",      32'(bus.dout), 32'h0A5);
    chk("t1_valid",     32'(bus.dout_valid), 32'h1);
    chk("t1_done_cnt",  32'(bus.done_cnt), 32'h1);
    chk("t1_src_ready", 32'(bus.src_ready), 32'h0);

    // HOLD without dout_ready: sources change, stray start ignored
    bus.src_valid = 3'b111;
    for (int i = 0; i < 5; i++) begin
      bus.src_data = {12'(i + 1), 12'(i + 2), 12'(i + 3)};
      bus.start = 1'b1;
      bus.sel = 2'd0;
      tick();
      chk("hold_dout",  32'(bus.dout), 32'h0A5);
      chk("hold_valid", 32'(bus.dout_valid), 32'h1);
    end
    bus.start = 1'b0;
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    chk("acc_valid", 32'(bus.dout_valid), 32'h0);
    chk("acc_busy",  32'(bus.busy), 32'h0);
    chk("acc_dout",  32'(bus.dout), 32'h0A5);
    chk("acc_done",  32'(bus.done_cnt), 32'h1);

    // Illegal select from IDLE
    bus.start = 1'b1;
    bus.sel = 2'd3;
    tick();
    bus.start = 1'b0;
    chk("ill_sel_err",   32'(bus.sel_err), 32'h1);
    chk("ill_busy",      32'(bus.busy), 32'h0);
    chk("ill_src_ready", 32'(bus.src_ready), 32'h0);
    tick();
    chk("ill_pulse_end", 32'(bus.sel_err), 32'h0);

    // Get into HOLD via source 0
    bus.start = 1'b1;
    bus.sel = 2'd0;
    bus.src_data = {12'h000, 12'h000, 12'h123};
    bus.src_valid = 3'b001;
    tick();
    bus.start = 1'b0;
    tick();
    chk("t2_dout", 32'(bus.dout), 32'h123);
    chk("t2_done", 32'(bus.done_cnt), 32'h2);

    // Back-to-back: accept and start sel=2 in the same cycle
    bus.src_valid = 3'b000;
    bus.dout_ready = 1'b1;
    bus.start = 1'b1;
    bus.sel = 2'd2;
    tick();
    bus.dout_ready = 1'b0;
    bus.start = 1'b0;
    bus.sel = 2'd0;
    chk("b2b_busy",      32'(bus.busy), 32'h1);
    chk("b2b_src_ready", 32'(bus.src_ready), 32'h4);
    chk("b2b_valid",     32'(bus.dout_valid), 32'h0);
    bus.src_data = {12'hFFF, 12'h000, 12'h000};
    bus.src_valid = 3'b100;
    tick();
    chk("b2b_dout",  32'(bus.dout), 32'hFFF);
    chk("b2b_valid2", 32'(bus.dout_valid), 32'h1);
    chk("b2b_done",  32'(bus.done_cnt), 32'h3);

    // Accept with illegal start in the same cycle
    bus.src_valid = 3'b000;
    bus.dout_ready = 1'b1;
    bus.start = 1'b1;
    bus.sel = 2'd3;
    tick();
    bus.dout_ready = 1'b0;
    bus.start = 1'b0;
    chk("hill_valid",   32'(bus.dout_valid), 32'h0);
    chk("hill_busy",    32'(bus.busy), 32'h0);
    chk("hill_sel_err", 32'(bus.sel_err), 32'h1);

    // WAIT on source 0 while only other sources are valid
    bus.start = 1'b1;
    bus.sel = 2'd0;
    bus.src_valid = 3'b110;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ign_src_ready", 32'(bus.src_ready), 32'h1);
      chk("ign_valid",     32'(bus.dout_valid), 32'h0);
    end
`ifdef RSEL_TIMEOUT_EN
    tick();
    chk("tmo_sel_err", 32'(bus.sel_err), 32'h1);
    chk("tmo_busy",    32'(bus.busy), 32'h0);
    chk("tmo_dout",    32'(bus.dout), 32'hFFF);
    chk("tmo_valid",   32'(bus.dout_valid), 32'h0);
    chk("tmo_done",    32'(bus.done_cnt), 32'h3);
    tick();
    chk("tmo_pulse_end", 32'(bus.sel_err), 32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("persist_busy",    32'(bus.busy), 32'h1);
      chk("persist_sel_err", 32'(bus.sel_err), 32'h0);
    end
`endif

    // Reset while in WAIT
    chk("prerst_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_src_ready", 32'(bus.src_ready), 32'h0);
    chk("mrst_dout",      32'(bus.dout), 32'h0);
    chk("mrst_valid",     32'(bus.dout_valid), 32'h0);
    chk("mrst_done",      32'(bus.done_cnt), 32'h0);
    chk("mrst_busy",      32'(bus.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
